// File: rtl/fib_engine.sv
// Recurrence engine: from two seed terms, generates up to DEPTH terms of a
// selectable two-term recurrence into a register-file, one term per cycle.
module fib_engine #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW:0]      n,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    input  logic [1:0]       mode,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic [2:0]       state_dbg
);

    // Handshake: start is taken (with n/seed0/seed1/mode) on an edge where
    // busy is low; busy then stays high until done, which pulses exactly once.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD0 = 3'd1,
        S_LOAD1 = 3'd2,
        S_CALC  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [AW:0]      neff_q, neff_d;
    logic [AW:0]      k_q, k_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW:0]      n_clamp;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   dif_ext;
    logic [WIDTH-1:0] term;
    logic             carry;

    assign n_clamp = (n > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : n;

    // a_q holds t[k-1] and b_q holds t[k-2]; bit WIDTH of the extended
    // results is the carry-out (add) or borrow (subtract).
    always_comb begin
        sum_ext = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, (mode_q == 2'b11)};
        dif_ext = {1'b0, a_q} - {1'b0, b_q};
        term    = sum_ext[WIDTH-1:0];
        carry   = sum_ext[WIDTH];
        case (mode_q)
            2'b01: begin
                term  = dif_ext[WIDTH-1:0];
                carry = dif_ext[WIDTH];
            end
            2'b10: begin
                term  = a_q ^ b_q;
                carry = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        neff_d   = neff_q;
        k_d      = k_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        we       = 1'b0;
        waddr    = '0;
        wdata    = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    b_d      = seed0;
                    a_d      = seed1;
                    mode_d   = mode;
                    neff_d   = n_clamp;
                    k_d      = (AW+1)'(2);
                    ovf_d    = 1'b0;
                    result_d = '0;
                    state_d  = (n_clamp == '0) ? S_DONE : S_LOAD0;
                end
            end
            S_LOAD0: begin
                we       = 1'b1;
                waddr    = '0;
                wdata    = b_q;
                result_d = b_q;
                state_d  = (neff_q == (AW+1)'(1)) ? S_DONE : S_LOAD1;
            end
            S_LOAD1: begin
                we       = 1'b1;
                waddr    = AW'(1);
                wdata    = a_q;
                result_d = a_q;
                state_d  = (neff_q == (AW+1)'(2)) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                we       = 1'b1;
                waddr    = k_q[AW-1:0];
                wdata    = term;
                result_d = term;
                ovf_d    = ovf_q | carry;
                b_d      = a_q;
                a_d      = term;
                k_d      = k_q + (AW+1)'(1);
                if (k_q == neff_q - (AW+1)'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= S_IDLE;
            neff_q   <= '0;
            k_q      <= '0;
            mode_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            neff_q   <= neff_d;
            k_q      <= k_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is flop-based so reset can clear every word at once.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rd_data   = mem_q[rd_addr];
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fib_engine.sv
// Randomized scoreboard bench for fib_engine: a sequence-level reference model
// predicts each run, and a negedge monitor compares everything the DUT shows.
module tb_fib_engine;

  localparam int W   = 32;
  localparam int D   = 64;
  localparam int AW  = 6;
  localparam int D8  = 16;
  localparam int AW8 = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (32-bit, 64 words) ----------------
  logic          start;
  logic [AW:0]   n_in;
  logic [W-1:0]  seed0, seed1;
  logic [1:0]    mode;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          busy, done, ovf;
  logic [W-1:0]  result;
  logic [2:0]    state_dbg;

  fib_engine #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n_in), .seed0(seed0), .seed1(seed1),
    .mode(mode), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .result(result), .ovf(ovf), .state_dbg(state_dbg)
  );

  // ---------------- DUT (8-bit, 16 words) ----------------
  logic           start8;
  logic [AW8:0]   n8;
  logic [7:0]     seed0_8, seed1_8;
  logic [1:0]     mode8;
  logic [AW8-1:0] rd_addr8;
  logic [7:0]     rd_data8, result8;
  logic           busy8, done8, ovf8;
  logic [2:0]     state_dbg8;

  fib_engine #(.WIDTH(8), .DEPTH(D8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .n(n8), .seed0(seed0_8), .seed1(seed1_8),
    .mode(mode8), .rd_addr(rd_addr8), .rd_data(rd_data8), .busy(busy8), .done(done8),
    .result(result8), .ovf(ovf8), .state_dbg(state_dbg8)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
    logic [31:0] act;
  } req_t;

  localparam int SEL_RD = 0, SEL_BUSY = 1, SEL_DONE = 2, SEL_RES = 3, SEL_OVF = 4;
  localparam int SEL_RD8 = 5, SEL_RES8 = 6, SEL_OVF8 = 7, SEL_STATE = 8, SEL_ACT = 9;

  req_t        chk_q[$];
  logic [31:0] exp_q[$];
  logic        exp_ovf_q[$];
  int          exp_neff_q[$];
  int          exp_e0_q[$];
  logic [31:0] model_mem [D];

  int n_vec     = 0;
  int n_miss    = 0;
  int busy_cnt  = 0;
  int done_seen = 0;

  function automatic logic [31:0] observe(input req_t r);
    case (r.sel)
      SEL_RD:    return rd_data;
      SEL_BUSY:  return {31'd0, busy};
      SEL_DONE:  return {31'd0, done};
      SEL_RES:   return result;
      SEL_OVF:   return {31'd0, ovf};
      SEL_RD8:   return {24'd0, rd_data8};
      SEL_RES8:  return {24'd0, result8};
      SEL_OVF8:  return {31'd0, ovf8};
      SEL_STATE: return {29'd0, state_dbg};
      default:   return r.act;
    endcase
  endfunction

  // Monitor: the only place comparisons are made and counted.
  always @(negedge clk) begin
    logic [31:0] e_res;
    logic        e_ovf;
    int          e_neff, e_e0;
    req_t        r;
    logic [31:0] a;
    if (busy) busy_cnt = busy_cnt + 1;
    else busy_cnt = 0;
    if (done) begin
      done_seen = done_seen + 1;
      n_vec = n_vec + 1;
      if (exp_q.size() == 0) begin
        n_miss = n_miss + 1;
        $display("FAIL unexpected_done: got done=1 expected no run pending (cycle %0d)", cyc);
      end else begin
        e_res  = exp_q.pop_front();
        e_ovf  = exp_ovf_q.pop_front();
        e_neff = exp_neff_q.pop_front();
        e_e0   = exp_e0_q.pop_front();
        if (result !== e_res) begin
          n_miss = n_miss + 1;
          $display("FAIL done_result: got %0h expected %0h", result, e_res);
        end
        n_vec = n_vec + 1;
        if (ovf !== e_ovf) begin
          n_miss = n_miss + 1;
          $display("FAIL done_ovf: got %0b expected %0b", ovf, e_ovf);
        end
        n_vec = n_vec + 1;
        if (cyc - e_e0 != e_neff) begin
          n_miss = n_miss + 1;
          $display("FAIL done_latency: got %0d expected %0d", cyc - e_e0, e_neff);
        end
        n_vec = n_vec + 1;
        if (busy_cnt != e_neff + 1) begin
          n_miss = n_miss + 1;
          $display("FAIL busy_cycles: got %0d expected %0d", busy_cnt, e_neff + 1);
        end
      end
    end
    while (chk_q.size() > 0) begin
      r = chk_q.pop_front();
      a = observe(r);
      n_vec = n_vec + 1;
      if (a !== r.exp) begin
        n_miss = n_miss + 1;
        $display("FAIL %s: got %0h expected %0h", r.name, a, r.exp);
      end
    end
  end

  task automatic push_chk(input string nm, input int sel, input logic [31:0] exp,
                          input logic [31:0] act = 32'd0);
    req_t r;
    r.name = nm;
    r.sel  = sel;
    r.exp  = exp;
    r.act  = act;
    chk_q.push_back(r);
  endtask

  // ---------------- reference model ----------------
  // Works on the whole sequence with 64-bit arithmetic; wrap and overflow
  // fall out of comparing against 2^32.
  function automatic void model_run(input logic [1:0] m, input logic [31:0] s0,
                                    input logic [31:0] s1, input int nn,
                                    output logic [31:0] res, output logic ov, output int ne);
    logic [63:0] t[$];
    logic [63:0] a, b, full;
    ne  = (nn > D) ? D : nn;
    res = 32'd0;
    ov  = 1'b0;
    for (int k = 0; k < ne; k++) begin
      if (k == 0) full = {32'd0, s0};
      else if (k == 1) full = {32'd0, s1};
      else begin
        a = t[k-1];
        b = t[k-2];
        case (m)
          2'd0: full = a + b;
          2'd1: begin
            if (a < b) begin
              ov   = 1'b1;
              full = a + 64'h1_0000_0000 - b;
            end else full = a - b;
          end
          2'd2: full = a ^ b;
          default: full = a + b + 64'd1;
        endcase
        if (full > 64'hFFFF_FFFF) begin
          ov   = 1'b1;
          full = full - 64'h1_0000_0000;
        end
      end
      t.push_back(full);
      model_mem[k] = full[31:0];
      res = full[31:0];
    end
  endfunction

  // ---------------- driver tasks ----------------
  logic [31:0] last_res;

  // Called one step after a posedge (or at a negedge); drives start for one edge.
  task automatic run(input logic [1:0] m, input logic [31:0] s0, input logic [31:0] s1,
                     input int nn, input bit noise);
    logic [31:0] res;
    logic        ov;
    int          ne;
    bit          got;
    start = 1'b1;
    mode  = m;
    seed0 = s0;
    seed1 = s1;
    n_in  = (AW+1)'(nn);
    @(posedge clk);
    #1;
    start = 1'b0;
    model_run(m, s0, s1, nn, res, ov, ne);
    last_res = res;
    exp_q.push_back(res);
    exp_ovf_q.push_back(ov);
    exp_neff_q.push_back(ne);
    exp_e0_q.push_back(cyc);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (noise) begin
        // Requests while busy must be ignored, so garbage is harmless here.
        start = 1'($urandom_range(0, 1));
        seed0 = $urandom;
        seed1 = $urandom;
        mode  = 2'($urandom_range(0, 3));
        n_in  = (AW+1)'($urandom_range(0, 127));
      end
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    if (!got) begin
      push_chk("done_timeout", SEL_ACT, 32'd0, 32'd1);
      void'(exp_q.pop_back());
      void'(exp_ovf_q.pop_back());
      void'(exp_neff_q.pop_back());
      void'(exp_e0_q.pop_back());
    end
  endtask

  task automatic sweep();
    for (int i = 0; i < D; i++) begin
      @(posedge clk);
      #1;
      rd_addr = AW'(i);
      push_chk($sformatf("mem[%0d]", i), SEL_RD, model_mem[i]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input logic [31:0] res, input logic ov);
    push_chk("idle_busy", SEL_BUSY, 32'd0);
    push_chk("idle_done", SEL_DONE, 32'd0);
    push_chk("held_result", SEL_RES, res);
    push_chk("held_ovf", SEL_OVF, {31'd0, ov});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          fib8 [D8];
    int          lat;
    bit          got;
    logic [31:0] rs;
    logic        ov;
    int          ne;

    rst_n    = 1'b1;
    start    = 1'b0;
    n_in     = '0;
    seed0    = '0;
    seed1    = '0;
    mode     = '0;
    rd_addr  = '0;
    start8   = 1'b0;
    n8       = '0;
    seed0_8  = '0;
    seed1_8  = '0;
    mode8    = '0;
    rd_addr8 = '0;
    last_res = '0;
    for (int i = 0; i < D; i++) model_mem[i] = 32'd0;

    // Reset held while the clock runs.
    repeat (3) @(posedge clk);
    #1;
    check_idle(32'd0, 1'b0);
    push_chk("reset_state", SEL_STATE, 32'd0);
    sweep();

    // Release at a negedge with start already up: first edge after release.
    @(negedge clk);
    rst_n = 1'b0;
    run(2'd0, 32'd0, 32'd1, 10, 1'b0);
    sweep();
    check_idle(32'd34, 1'b0);

    run(2'd0, 32'd11, 32'd12, 0, 1'b0);
    sweep();
    check_idle(32'd0, 1'b0);

    run(2'd0, 32'd7, 32'd9, 1, 1'b1);
    push_chk("n1_result", SEL_RES, 32'd7);
    run(2'd0, 32'd7, 32'd9, 2, 1'b1);
    push_chk("n2_result", SEL_RES, 32'd9);
    sweep();

    run(2'd1, 32'd5, 32'd3, 4, 1'b0);
    sweep();
    push_chk("sub_ovf", SEL_OVF, 32'd1);

    run(2'd2, 32'd5, 32'd3, 4, 1'b0);
    sweep();
    push_chk("xor_ovf", SEL_OVF, 32'd0);

    run(2'd3, $urandom, $urandom, 20, 1'b0);
    sweep();

    run(2'd0, 32'd1, 32'd1, 100, 1'b1);
    sweep();

    for (int r = 0; r < 10; r++) begin
      run(2'($urandom_range(0, 3)), $urandom, $urandom, int'($urandom_range(0, 100)),
          1'($urandom_range(0, 1)));
      sweep();
      model_run(2'd0, 32'd0, 32'd0, 0, rs, ov, ne);
    end

    // Abort: a clamped run interrupted by reset at E30.
    start = 1'b1;
    mode  = 2'd0;
    seed0 = 32'd3;
    seed1 = 32'd4;
    n_in  = (AW+1)'(100);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < D; i++) model_mem[i] = 32'd0;
    check_idle(32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    push_chk("abort_done", SEL_DONE, 32'd0);
    push_chk("abort_busy", SEL_BUSY, 32'd0);
    sweep();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Narrow instance: 8-bit wrap with carry-out.
    start8  = 1'b1;
    mode8   = 2'd0;
    seed0_8 = 8'd0;
    seed1_8 = 8'd1;
    n8      = (AW8+1)'(15);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done8) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
    @(posedge clk);
    #1;
    push_chk("w8_done_seen", SEL_ACT, 32'd1, {31'd0, got});
    push_chk("w8_latency", SEL_ACT, 32'd15, lat);
    push_chk("w8_result", SEL_RES8, 32'd121);
    push_chk("w8_ovf", SEL_OVF8, 32'd1);
    fib8[0] = 0;
    fib8[1] = 1;
    for (int k = 2; k < 15; k++) fib8[k] = (fib8[k-1] + fib8[k-2]) % 256;
    fib8[15] = 0;
    for (int i = 0; i < D8; i++) begin
      @(posedge clk);
      #1;
      rd_addr8 = AW8'(i);
      push_chk($sformatf("w8_mem[%0d]", i), SEL_RD8, fib8[i]);
    end
    @(posedge clk);
    #1;
    push_chk("w8_mem13_const", SEL_ACT, 32'd233, fib8[13]);

    for (int i = 0; i < 20 && chk_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fib_engine.md
FIB_ENGINE -- requirements
Module: fib_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath and storage word width.
REQ-002 SHALL have parameter DEPTH, default 64, number of storage words, power of two, at least 4.
REQ-003 SHALL have derived parameter AW = clog2(DEPTH), address and count width.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-high reset (asserted = 1).
REQ-006 SHALL have port start, input, 1, request to generate a sequence.
REQ-007 SHALL have port n, input, AW+1, number of terms requested; sampled with start.
REQ-008 SHALL have port seed0, input, WIDTH, term 0; sampled with start.
REQ-009 SHALL have port seed1, input, WIDTH, term 1; sampled with start.
REQ-010 SHALL have port mode, input, 2, recurrence select; sampled with start.
REQ-011 SHALL have port rd_addr, input, AW, readback address.
REQ-012 SHALL have port rd_data, output, WIDTH, combinational read of storage word rd_addr.
REQ-013 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port result, output, WIDTH, last term written; held until the next accepted start.
REQ-016 SHALL have port ovf, output, 1, sticky arithmetic overflow flag for the current run.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD0, LOAD1, CALC and DONE.
REQ-018 SHALL accept start only in IDLE and ignore start in all other states.
REQ-019 SHALL, on acceptance, latch seed0, seed1, mode and neff = min(n, DEPTH), clear ovf, and clear result.
REQ-020 SHALL, on acceptance, transition to DONE if neff = 0, else to LOAD0.
REQ-021 SHALL, in LOAD0, write mem[0] = seed0 and result = seed0, then go to DONE if neff = 1, else to LOAD1.
REQ-022 SHALL, in LOAD1, write mem[1] = seed1 and result = seed1, then go to DONE if neff = 2, else to CALC.
REQ-023 SHALL, in CALC, write one term per cycle, mem[k] = f(t[k-1], t[k-2]) for k = 2..neff-1, and go to DONE after writing k = neff-1.
REQ-024 SHALL hold the two previous terms in internal registers and SHALL NOT obtain them from a storage read.
REQ-025 SHALL compute f as follows: mode 00 a+b; mode 01 a-b, where a = t[k-1] and b = t[k-2]; mode 10 a^b; mode 11 a+b+1.
REQ-026 SHALL compute all results modulo 2^WIDTH, so arithmetic wraps.
REQ-027 SHALL set ovf on unsigned carry-out in modes 00 and 11, and on borrow in mode 01.
REQ-028 SHALL never set ovf in mode 10.
REQ-029 SHALL keep ovf set once set, until the next accepted start.
REQ-030 SHALL update result to each term as that term is written.
REQ-031 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-032 SHALL give latency such that, with start accepted at edge E0, done is high between edges E(neff) and E(neff+1).
REQ-033 SHALL make rd_data = mem[rd_addr] combinationally, so a word written at edge E is visible on rd_data after E.
REQ-034 SHALL leave storage words at and above neff unchanged by a run.
REQ-035 SHALL clamp an n greater than DEPTH to DEPTH and SHALL raise no error for it.

Reset
REQ-036 SHALL, while rst_n = 1 and regardless of clk, force state = IDLE, busy = 0, done = 0, ovf = 0, result = 0, and all storage words = 0.
REQ-037 SHALL, on reset asserted mid-run, abort the run immediately with no done pulse; words already written are cleared by REQ-036.
REQ-038 SHALL accept a start in the first cycle after reset release.

Verification
REQ-039 SHALL cover mode 00, seeds 0/1, n = 10: done after E10; result = 34; mem[0..9] = 0,1,1,2,3,5,8,13,21,34; ovf = 0.
REQ-040 SHALL cover WIDTH = 8, mode 00, seeds 0/1, n = 15: mem[13] = 233 and mem[14] = 121 (377 mod 256); ovf = 1.
REQ-041 SHALL cover n = 0: done high after E0; busy high exactly one cycle; result = 0; no storage write.
REQ-042 SHALL cover n = 1, then n = 2, seeds 7/9: result = 7 with done after E1, then result = 9 with done after E2; start pulses during busy are ignored.
REQ-043 SHALL cover mode 01, seeds 5/3: mem[2] = 0xFFFFFFFE and ovf = 1; mode 10, seeds 5/3, n = 4: mem[2..3] = 6,5.
REQ-044 SHALL cover n = 100 with DEPTH = 64: clamped to 64; done after E64; rst_n pulsed at E30 of a second run gives busy = 0, all words 0, no done.
